// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    REPORT,
    WAIT_RELEASE
  } state_e;

  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned DEF_ROWS   = 4;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned MAX_LINES  = 16;

  // Active-low one-hot row pattern; callers truncate to their row count.
  function automatic logic [MAX_LINES-1:0] row_onehot_n(input logic [3:0] idx);
    return ~(MAX_LINES'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key code delivery channel: valid/ready handshake from scanner to consumer.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Resets to all-ones so the idle (released) state is seen during reset.
module col_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives active-low rows, confirms a press with a
// second sample, reports row*COLS+col over a valid/ready channel, and waits
// for a qualified release before scanning on.
// Build option: define KEYPAD_REPEAT_EN to re-report a key that stays held
// for REPEAT_TICKS cycles while waiting for release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned SCAN_TICKS   = 27000,
  parameter int unsigned REPEAT_TICKS = 2700000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COLS-1:0]         col_in,
  output logic [ROWS-1:0]         row_out,
  output logic [$clog2(ROWS)-1:0] scan_row,
  keypad_scanner_if.master        kbus
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned MAX_T = (SCAN_TICKS > REPEAT_TICKS) ? SCAN_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);

  state_e                state;
  logic [ROW_W-1:0]      r;
  logic [COL_W-1:0]      col;
  logic [CNT_W-1:0]      cnt;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]      rpt_cnt;
`endif

  logic [COLS-1:0]       col_s;
  logic [COL_W-1:0]      col_low_c;
  logic [ROW_W-1:0]      next_row_c;
  logic                  tick_c;
  logic                  all_high_c;

  col_sync #(.W(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );

  // Lowest-index low column wins when several keys in a row are down.
  always_comb begin
    col_low_c = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (!col_s[i]) col_low_c = COL_W'(i);
    end
  end

  assign tick_c     = (cnt == CNT_W'(SCAN_TICKS - 1));
  assign all_high_c = &col_s;
  assign next_row_c = (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);

  // Row strobe is a pure decode of the registered row index.
  assign row_out  = ROWS'(row_onehot_n(4'(r)));
  assign scan_row = r;

  assign kbus.key_code  = key_code;
  assign kbus.key_valid = key_valid;

  // Scan / confirm / report / release-qualify state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      r         <= '0;
      col       <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      case (state)
        SCAN: begin
          if (tick_c) begin
            cnt <= '0;
            if (all_high_c) begin
              r <= next_row_c;
            end else begin
              col   <= col_low_c;
              state <= CONFIRM;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CONFIRM: begin
          if (tick_c) begin
            cnt <= '0;
            if (!col_s[col]) begin
              key_code  <= KEY_CODE_W'(r) * KEY_CODE_W'(COLS) + KEY_CODE_W'(col);
              key_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              r     <= next_row_c;
              state <= SCAN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        REPORT: begin
          if (key_valid && kbus.key_ready) begin
            key_valid <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
`endif
          end
        end

        WAIT_RELEASE: begin
          // Release needs SCAN_TICKS consecutive all-high samples.
          if (!all_high_c) begin
            cnt <= '0;
          end else if (tick_c) begin
            cnt   <= '0;
            r     <= next_row_c;
            state <= SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`ifdef KEYPAD_REPEAT_EN
          // Held key re-reports the same code after REPEAT_TICKS low cycles.
          if (!col_s[col]) begin
            if (rpt_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
              rpt_cnt   <= '0;
              key_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
          end else begin
            rpt_cnt <= '0;
          end
`endif
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_TICKS=4, REPEAT_TICKS=40).
// A physical keypad model turns pressed keys plus the driven rows into
// column levels; expected codes and timing come from the behavioural rules.
module tb_keypad_scanner;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ST      = 4;
  localparam int RT      = 40;
  localparam int LAT_MAX = 2 + (ROWS + 1) * ST + 1;

`ifdef KEYPAD_REPEAT_EN
  localparam int TAB_MAX  = 99;
  localparam int LONG_MIN = 3;
  localparam int LONG_MAX = 99;
`else
  localparam int TAB_MAX  = 1;
  localparam int LONG_MIN = 1;
  localparam int LONG_MAX = 1;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [1:0]  scan_row;
  logic [15:0] press_mask;
  logic [3:0]  glitch;

  keypad_scanner_if kbus ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(ST), .REPEAT_TICKS(RT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .scan_row (scan_row),
    .kbus     (kbus)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  function automatic logic [3:0] keypad_cols(input logic [3:0] rows_n, input logic [15:0] pressed);
    logic [3:0] cols;
    cols = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[rr * 4 + cc] && !rows_n[rr]) cols[cc] = 1'b0;
    return cols;
  endfunction

  assign col_in = keypad_cols(row_out, press_mask) & ~glitch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] got_q[$];

  typedef struct {
    int         row;
    int         col;
    int         hold;
    int         rdly;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next active edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge: structural invariants plus handshake capture.
  task automatic observe();
    @(negedge clk);
    chk("row_onehot", 32'($countones(~row_out)), 32'd1);
    chk("row_matches_scan_row", 32'(row_out[scan_row]), 32'd0);
    if (!rst && kbus.key_valid && kbus.key_ready) got_q.push_back(kbus.key_code);
  endtask

  // One press episode: press, hold, release, then idle long enough to requalify.
  task automatic run_press(input int r, input int c, input int hold, input int rdly,
                           input bit rnd, input logic [3:0] exp_code,
                           input int min_rep, input int max_rep);
    bit seen;
    int since;
    seen  = 1'b0;
    since = 0;
    got_q.delete();
    kbus.key_ready = (rdly == 0);
    for (int k = 0; k < hold + 50; k++) begin
      next_cycle();
      if (k == 0) press_mask = 16'(1) << (r * 4 + c);
      if (k == hold) press_mask = '0;
      if (rnd) kbus.key_ready = ($urandom_range(0, 3) != 0);
      else if (rdly > 0) kbus.key_ready = seen && (since >= rdly);
      observe();
      if (kbus.key_valid && !seen) begin
        seen = 1'b1;
        chk("report_latency", 32'(k <= LAT_MAX), 32'd1);
        chk("first_code", 32'(kbus.key_code), 32'(exp_code));
      end else if (seen && !rnd && rdly > 0 && since < rdly) begin
        chk("backpressure_valid", 32'(kbus.key_valid), 32'd1);
        chk("backpressure_code", 32'(kbus.key_code), 32'(exp_code));
      end
      if (seen) since++;
    end
    chk("valid_seen", 32'(seen), 32'd1);
    chk("report_count_min", 32'(got_q.size() >= min_rep), 32'd1);
    chk("report_count_max", 32'(got_q.size() <= max_rep), 32'd1);
    foreach (got_q[i]) chk("report_code", 32'(got_q[i]), 32'(exp_code));
    chk("valid_low_after", 32'(kbus.key_valid), 32'd0);
  endtask

  initial begin
    bit seen;

    vecs[0] = '{row: 2, col: 1, hold: 60, rdly: 0,  exp_code: 4'd9};
    vecs[1] = '{row: 0, col: 0, hold: 40, rdly: 20, exp_code: 4'd0};
    vecs[2] = '{row: 1, col: 2, hold: 30, rdly: 0,  exp_code: 4'd6};
    vecs[3] = '{row: 0, col: 3, hold: 30, rdly: 5,  exp_code: 4'd3};
    vecs[4] = '{row: 3, col: 0, hold: 30, rdly: 0,  exp_code: 4'd12};
    vecs[5] = '{row: 3, col: 3, hold: 30, rdly: 0,  exp_code: 4'd15};

    rst            = 1'b1;
    press_mask     = '0;
    glitch         = '0;
    kbus.key_ready = 1'b1;

    // Reset state.
    repeat (3) next_cycle();
    chk("rst_row_out", 32'(row_out), 32'hE);
    chk("rst_scan_row", 32'(scan_row), 32'd0);
    chk("rst_key_valid", 32'(kbus.key_valid), 32'd0);
    chk("rst_key_code", 32'(kbus.key_code), 32'd0);

    // Idle scan: each row held low for SCAN_TICKS cycles in order.
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      observe();
      chk("idle_row", 32'(row_out), 32'(4'hF & ~(4'd1 << ((k / ST) % ROWS))));
      chk("idle_valid", 32'(kbus.key_valid), 32'd0);
      next_cycle();
    end

    // Glitch on column 3 caught by the row-0 sample but gone at confirm.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      next_cycle();
      if (j == 1) glitch = 4'b1000;
      if (j == 3) glitch = 4'b0000;
      observe();
      chk("glitch_row", 32'(row_out), (j < 8) ? 32'hE : (j < 12) ? 32'hD : 32'hB);
      chk("glitch_valid", 32'(kbus.key_valid), 32'd0);
    end
    got_q.delete();
    for (int j = 0; j < 20; j++) begin
      next_cycle();
      observe();
    end
    chk("glitch_no_report", 32'(got_q.size()), 32'd0);

    // Table-driven presses.
    for (int i = 0; i < 6; i++)
      run_press(vecs[i].row, vecs[i].col, vecs[i].hold, vecs[i].rdly, 1'b0,
                vecs[i].exp_code, 1, TAB_MAX);

    // Long hold: single report, or periodic repeats when enabled.
    run_press(3, 3, 200, 0, 1'b0, 4'd15, LONG_MIN, LONG_MAX);

    // Randomized presses with random consumer readiness.
    for (int n = 0; n < 30; n++) begin
      int rr, cc, hh;
      rr = int'($urandom_range(0, ROWS - 1));
      cc = int'($urandom_range(0, COLS - 1));
      hh = 24 + int'($urandom_range(0, 21));
      run_press(rr, cc, hh, 0, 1'b1, 4'(rr * COLS + cc), 1, 1);
    end

    // Asynchronous reset while a report is pending.
    kbus.key_ready = 1'b0;
    got_q.delete();
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_cycle();
      if (k == 0) press_mask = 16'h0001;
      observe();
      if (kbus.key_valid) seen = 1'b1;
    end
    chk("rst_mid_report_reached", 32'(seen), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(kbus.key_valid), 32'd0);
    chk("rst_async_row_out", 32'(row_out), 32'hE);
    chk("rst_async_scan_row", 32'(scan_row), 32'd0);
    chk("rst_async_code", 32'(kbus.key_code), 32'd0);
    press_mask = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    kbus.key_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      observe();
      chk("post_rst_no_valid", 32'(kbus.key_valid), 32'd0);
    end
    chk("post_rst_no_report", 32'(got_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the rows of a 4x4 matrix keypad and reads the column returns.
- Confirms each key press with a second sample and encodes it as a 4-bit key code.
- Delivers each code over a valid/ready handshake to the display/command logic.
- This block is the drive side of the keypad interface. It generates the row strobes that the column sense lines respond to, and it performs its own settle/confirm timing.

Parameters:
- ROWS, 4, number of row lines (driven).
- COLS, 4, number of column lines (sensed); ROWS*COLS <= 16.
- SCAN_TICKS, 27000, clock cycles a row is held low before columns are sampled. Also used as the confirm and release qualification time.
- REPEAT_TICKS, 2700000, cycles a key must stay held before a repeat report. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col_in  input  COLS  raw column lines, active-low (pulled up externally), asynchronous to clk
- row_out  output  ROWS  row drive, active-low one-hot
- key_code  output  4  row_idx*COLS + col_idx of the reported key
- key_valid  output  1  key_code valid; held until accepted
- key_ready  input  1  consumer accepts the code when key_valid && key_ready at a posedge
- scan_row  output  $clog2(ROWS)  index of the row currently driven (debug/LED)

Behaviour:
- Reset (asynchronous, rst=1):
  - state=SCAN, row index 0, row_out=4'b1110, key_valid=0, key_code=0, scan_row=0.
  - Counter cleared; synchronizer flops set to all-ones (released).
  - rst released mid-operation (including mid-REPORT) discards any pending code; no valid is produced.
- col_in passes through a 2-flop synchronizer. Internal col_s lags col_in by 2 cycles.
- Counter width is $clog2(max(SCAN_TICKS,REPEAT_TICKS)+1). It counts 0..SCAN_TICKS-1, and the terminal count is "tick".
- SCAN:
  - Drive row r low and count.
  - On tick, sample col_s.
    - If all columns are high: r <= (r==ROWS-1) ? 0 : r+1, wrapping; counter restarts.
    - Otherwise latch col = lowest index with col_s low (lowest column wins on multiple presses) and go to CONFIRM.
- CONFIRM:
  - Hold row r and count another SCAN_TICKS.
  - On tick, if col_s[col] is still low, go to REPORT. Otherwise treat it as a glitch and advance to row r+1 in SCAN.
- REPORT:
  - key_code <= r*COLS+col, registered on REPORT entry; key_valid=1.
  - key_code and key_valid stay stable until handshake.
  - On key_valid && key_ready, drop key_valid next cycle and go to WAIT_RELEASE.
  - The key may be released while waiting for ready; the code is still delivered.
- WAIT_RELEASE:
  - Hold row r.
  - Counter counts consecutive cycles with col_s all high; any low column resets it.
  - On tick, advance to row r+1 in SCAN.
  - A held key produces exactly one report.
- Report latency from a stable press: at most 2 sync cycles + (ROWS+1)*SCAN_TICKS + 1 cycles after the press settles.
- row_out is combinationally decoded from registered r, so it is glitch-free per cycle (one-hot encode of a register).

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - WAIT_RELEASE runs a second counter of cycles with col_s[col] low.
  - When that counter reaches REPEAT_TICKS, re-enter REPORT with the same key_code, and the counter restarts after the handshake.
  - Release qualification is unchanged.
- Undefined:
  - The second counter and its comparator are absent.
  - Exactly one report per press.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, CONFIRM, REPORT, WAIT_RELEASE}.
  - KEY_CODE_W=4.
  - Default ROWS/COLS constants.
  - Function row_onehot_n(idx) returning the active-low row pattern.
- Sub-module col_sync: parameterised-width 2-flop synchronizer with asynchronous active-high reset to all-ones. Instantiated once on col_in.

Test Plan (SCAN_TICKS=4, REPEAT_TICKS=40, key_ready=1 unless stated):
- Idle: col_in=4'hF for 100 cycles -> row_out cycles 1110,1101,1011,0111, each for 4 cycles; key_valid stays 0.
- Press row 2/col 1 (col_in[1] low while row_out=1011, held 60 cycles) -> one key_valid pulse with key_code=9; no second pulse until release plus 4 high cycles.
- Glitch: col_in[3] low for 2 cycles, confirm sample fails -> key_valid never asserts; scan resumes at the next row.
- Backpressure: key_ready=0 during a press of row 0/col 0, then key_ready=1 after 20 cycles -> key_valid high with key_code=0 stable for the whole 20 cycles; accepted once.
- rst pulsed asynchronously mid-REPORT -> key_valid=0 and row_out=1110 immediately; no report after release of rst while the key is up.
- With KEYPAD_REPEAT_EN, key row 3/col 3 held 200 cycles -> key_code=15 reported, then repeated roughly every 40 cycles. Without the macro -> a single report.
